// File: rtl/vend_pkg.sv
// Shared types and constants for the vending checkout stage.
// State encodings, coin select codes and coin face values.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_REFUND  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CS_1  = 2'b00,
        CS_5  = 2'b01,
        CS_10 = 2'b10,
        CS_20 = 2'b11
    } coin_e;

    localparam logic [7:0] COIN_1  = 8'd1;
    localparam logic [7:0] COIN_5  = 8'd5;
    localparam logic [7:0] COIN_10 = 8'd10;
    localparam logic [7:0] COIN_20 = 8'd20;
    localparam logic [7:0] AMT_MAX = 8'd255;

endpackage

// File: rtl/coin_value_decode.sv
// Combinational map from coin select code to face value.
module coin_value_decode
    import vend_pkg::*;
(
    input  logic [1:0] coin_sel,
    output logic [7:0] value
);

    always_comb begin
        value = COIN_1;
        unique case (coin_e'(coin_sel))
            CS_1:  value = COIN_1;
            CS_5:  value = COIN_5;
            CS_10: value = COIN_10;
            CS_20: value = COIN_20;
        endcase
    end

endmodule

// File: rtl/vend_payment.sv
// Checkout stage: latch amount due, collect coins, then dispense
// with change or refund on cancel / coin-free timeout.
module vend_payment
    import vend_pkg::*;
#(
    parameter int AMT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] price_in,
    input  logic             coin_valid,
    input  logic [1:0]       coin_sel,
    input  logic             cancel,
    output logic [AMT_W-1:0] due,
    output logic [AMT_W-1:0] paid,
    output logic [AMT_W-1:0] change,
    output logic             dispense,
    output logic             refund,
    output logic             busy,
    output logic [1:0]       state_o
);

    localparam int TW = $clog2(TIMEOUT);

    state_e           state, state_nx;
    logic [AMT_W-1:0] due_nx, paid_nx, change_nx;
    logic [AMT_W-1:0] coin_amt, paid_sum;
    logic [AMT_W:0]   sum;
    logic [TW-1:0]    timer, timer_nx;
    logic             disp_nx, ref_nx;
    logic [7:0]       coin_val;

    coin_value_decode u_dec (
        .coin_sel (coin_sel),
        .value    (coin_val)
    );

    assign coin_amt = AMT_W'(coin_val);
    assign sum      = {1'b0, paid} + {1'b0, coin_amt};

    // Saturate the running total at the all-ones amount
    always_comb begin
        paid_sum = paid;
        if (coin_valid)
            paid_sum = sum[AMT_W] ? '1 : sum[AMT_W-1:0];
    end

    always_comb begin
        state_nx  = state;
        due_nx    = due;
        paid_nx   = paid;
        change_nx = change;
        timer_nx  = timer;
        disp_nx   = 1'b0;
        ref_nx    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && price_in != '0) begin
                    due_nx    = price_in;
                    paid_nx   = '0;
                    change_nx = '0;
                    timer_nx  = '0;
                    state_nx  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                timer_nx = coin_valid ? '0 : timer + TW'(1);
                if (cancel) begin
                    paid_nx   = paid_sum;
                    change_nx = paid_sum;
                    ref_nx    = 1'b1;
                    state_nx  = ST_REFUND;
                end else if (paid_sum >= due) begin
                    paid_nx   = paid_sum;
                    change_nx = paid_sum - due;
                    disp_nx   = 1'b1;
                    state_nx  = ST_DONE;
                end else if (!coin_valid && timer == TW'(TIMEOUT - 1)) begin
                    change_nx = paid;
                    ref_nx    = 1'b1;
                    state_nx  = ST_REFUND;
                end else begin
                    paid_nx = paid_sum;
                end
            end
            ST_DONE:   state_nx = ST_IDLE;
            ST_REFUND: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            due      <= '0;
            paid     <= '0;
            change   <= '0;
            timer    <= '0;
            dispense <= 1'b0;
            refund   <= 1'b0;
        end else begin
            state    <= state_nx;
            due      <= due_nx;
            paid     <= paid_nx;
            change   <= change_nx;
            timer    <= timer_nx;
            dispense <= disp_nx;
            refund   <= ref_nx;
        end
    end

    assign busy    = (state != ST_IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_vend_payment.sv
// Scoreboard bench for the vending checkout stage (TIMEOUT=8).
module tb_vend_payment;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] price_in = '0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_sel = '0;
    logic       cancel = 1'b0;
    logic [7:0] due, paid, change;
    logic       dispense, refund, busy;
    logic [1:0] state_o;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int kind;
        int chg;
        int pd;
    } exp_t;

    exp_t sb[$];

    vend_payment #(.AMT_W(8), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .price_in   (price_in),
        .coin_valid (coin_valid),
        .coin_sel   (coin_sel),
        .cancel     (cancel),
        .due        (due),
        .paid       (paid),
        .change     (change),
        .dispense   (dispense),
        .refund     (refund),
        .busy       (busy),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic begin_txn(input int price);
        start = 1'b1;
        price_in = 8'(price);
        tick();
        start = 1'b0;
    endtask

    task automatic coin(input logic [1:0] sel);
        coin_valid = 1'b1;
        coin_sel = sel;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic push(input int kind, input int chg, input int pd);
        exp_t e;
        e.kind = kind;
        e.chg = chg;
        e.pd = pd;
        sb.push_back(e);
    endtask

    // Every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst && (dispense || refund)) begin
            chk("pulse_excl", int'(dispense && refund), 0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_kind", dispense ? 1 : 2, e.kind);
                chk("sb_change", int'(change), e.chg);
                chk("sb_paid", int'(paid), e.pd);
            end
        end
    end

    initial begin
        rst = 1'b0;
        tick();
        chk("rst_state", int'(state_o), 0);
        chk("rst_due", int'(due), 0);
        chk("rst_paid", int'(paid), 0);
        chk("rst_change", int'(change), 0);
        chk("rst_pulses", int'({dispense, refund}), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        tick();

        begin_txn(12);
        chk("t1_state", int'(state_o), 1);
        chk("t1_due", int'(due), 12);
        chk("t1_busy", int'(busy), 1);
        coin(2'b10);
        chk("t1_paid10", int'(paid), 10);
        push(1, 3, 15);
        coin(2'b01);
        chk("t1_disp", int'(dispense), 1);
        chk("t1_done", int'(state_o), 2);
        tick();
        chk("t1_busy_drop", int'(busy), 0);
        chk("t1_disp_low", int'(dispense), 0);
        chk("t1_chg_hold", int'(change), 3);
        chk("t1_paid_hold", int'(paid), 15);

        begin_txn(12);
        chk("t2_chg_clr", int'(change), 0);
        coin(2'b10);
        start = 1'b1;
        price_in = 8'd99;
        tick();
        start = 1'b0;
        chk("t2_due_kept", int'(due), 12);
        coin(2'b00);
        push(1, 0, 12);
        coin(2'b00);
        chk("t2_disp", int'(dispense), 1);
        chk("t2_chg", int'(change), 0);
        tick();

        begin_txn(12);
        coin(2'b01);
        push(2, 6, 6);
        cancel = 1'b1;
        coin(2'b00);
        cancel = 1'b0;
        chk("t3_refund", int'(refund), 1);
        chk("t3_nodisp", int'(dispense), 0);
        chk("t3_state", int'(state_o), 3);
        tick();
        chk("t3_idle", int'(state_o), 0);

        begin_txn(12);
        coin(2'b01);
        push(2, 5, 5);
        idle(7);
        chk("t4_pre_to", int'(refund), 0);
        chk("t4_still", int'(state_o), 1);
        idle(1);
        chk("t4_refund", int'(refund), 1);
        chk("t4_chg", int'(change), 5);
        tick();

        begin_txn(12);
        coin(2'b00);
        idle(6);
        coin(2'b00);
        push(2, 2, 2);
        idle(7);
        chk("t4b_timer_rst", int'(busy), 1);
        idle(1);
        chk("t4b_refund", int'(refund), 1);
        tick();

        begin_txn(250);
        for (int i = 0; i < 12; i++) coin(2'b11);
        chk("t5_paid240", int'(paid), 240);
        push(1, 5, 255);
        coin(2'b11);
        chk("t5_sat", int'(paid), 255);
        chk("t5_disp", int'(dispense), 1);
        chk("t5_chg", int'(change), 5);
        tick();

        begin_txn(12);
        coin(2'b10);
        chk("t6_paid10", int'(paid), 10);
        rst = 1'b0;
        tick();
        chk("t6_state", int'(state_o), 0);
        chk("t6_vals", int'({due, paid, change}), 0);
        chk("t6_pulses", int'({dispense, refund}), 0);
        rst = 1'b1;
        begin_txn(0);
        chk("t6_zero_busy", int'(busy), 0);
        chk("t6_zero_due", int'(due), 0);
        idle(3);
        chk("t6_nopulse", int'({dispense, refund}), 0);

        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
